// File: rtl/note_duration_timer.sv
// Note duration timer: counts a loaded number of beat ticks and emits a one-cycle
// done pulse. It can be paused, aborted by a new load, and reset synchronously.
module note_duration_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             beat,
  input  logic             play_enable,
  input  logic             load_new_note,
  input  logic [WIDTH-1:0] duration,
  output logic             note_active,
  output logic             done_with_note,
  output logic [WIDTH-1:0] beats_remaining,
  output logic             paused
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic active;
    logic paused;
    logic done;
  } flags_t;

  state_t           state;
  flags_t           flags;
  logic [WIDTH-1:0] count;

  // Flag values that go with a state; they are loaded together with the state
  // so every output comes straight from a flop.
  function automatic flags_t flags_of(state_t s);
    flags_t f;
    f.active = (s == PLAYING) || (s == PAUSED);
    f.paused = (s == PAUSED);
    f.done   = (s == DONE);
    return f;
  endfunction

  // Where a load lands: a zero-length note completes at once.
  function automatic state_t load_target(logic [WIDTH-1:0] d, logic en);
    if (d == '0)
      return DONE;
    else if (en)
      return PLAYING;
    else
      return PAUSED;
  endfunction

  // NOTE: every state flop uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      flags <= '0;
      count <= '0;
    end else if (load_new_note) begin
      // A load wins over a coincident beat and aborts any note in progress.
      state <= load_target(duration, play_enable);
      flags <= flags_of(load_target(duration, play_enable));
      count <= duration;
    end else begin
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        PLAYING: begin
          if (!play_enable) begin
            state <= PAUSED;
            flags <= flags_of(PAUSED);
          end else if (beat && count != '0) begin
            count <= count - 1'b1;
            if (count == WIDTH'(1)) begin
              state <= DONE;
              flags <= flags_of(DONE);
            end
          end
        end
        PAUSED: begin
          if (play_enable) begin
            state <= PLAYING;
            flags <= flags_of(PLAYING);
          end
        end
        DONE: begin
          state <= IDLE;
          flags <= flags_of(IDLE);
        end
        default: begin
          state <= IDLE;
          flags <= '0;
        end
      endcase
    end
  end

  assign note_active     = flags.active;
  assign paused          = flags.paused;
  assign done_with_note  = flags.done;
  assign beats_remaining = count;

endmodule

// File: tb/tb_note_duration_timer.sv
// Self-checking bench for note_duration_timer: a per-cycle vector table plus
// hand-written multi-cycle sequences for pause, abort, reset and full-range notes.
module tb_note_duration_timer;

  localparam int WIDTH = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             beat = 1'b0;
  logic             play_enable = 1'b0;
  logic             load_new_note = 1'b0;
  logic [WIDTH-1:0] duration = '0;
  logic             note_active;
  logic             done_with_note;
  logic [WIDTH-1:0] beats_remaining;
  logic             paused;

  int vectors = 0;
  int miscompares = 0;

  note_duration_timer #(.WIDTH(WIDTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .beat            (beat),
    .play_enable     (play_enable),
    .load_new_note   (load_new_note),
    .duration        (duration),
    .note_active     (note_active),
    .done_with_note  (done_with_note),
    .beats_remaining (beats_remaining),
    .paused          (paused)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic             rst;
    logic             bt;
    logic             en;
    logic             ld;
    logic [WIDTH-1:0] dur;
    logic             exp_active;
    logic             exp_done;
    logic [WIDTH-1:0] exp_rem;
    logic             exp_paused;
  } vec_t;

  localparam int NVEC = 33;
  vec_t table_v [NVEC];

  function automatic vec_t v(logic rst, logic bt, logic en, logic ld, int dur,
                             logic a, logic d, int rem, logic p);
    vec_t r;
    r.rst = rst; r.bt = bt; r.en = en; r.ld = ld; r.dur = WIDTH'(dur);
    r.exp_active = a; r.exp_done = d; r.exp_rem = WIDTH'(rem); r.exp_paused = p;
    return r;
  endfunction

  // Drive one cycle of inputs away from the edge, then sample just after it.
  task automatic step(input logic rst, input logic bt, input logic en,
                      input logic ld, input int dur);
    @(negedge clock);
    reset = rst; beat = bt; play_enable = en; load_new_note = ld;
    duration = WIDTH'(dur);
    @(posedge clock);
    #1;
    reset = 1'b0; beat = 1'b0; load_new_note = 1'b0;
  endtask

  task automatic check(input string name, input logic a, input logic d,
                       input int rem, input logic p);
    logic [WIDTH+2:0] act, exp;
    act = {note_active, done_with_note, beats_remaining, paused};
    exp = {a, d, WIDTH'(rem), p};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got active=%b done=%b rem=%0d paused=%b, want active=%b done=%b rem=%0d paused=%b",
               name, note_active, done_with_note, beats_remaining, paused, a, d, rem, p);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Idle cycles with playback held at the given enable, checking outputs stay put.
  task automatic idle_hold(input string name, input int n, input logic en,
                           input logic a, input int rem, input logic p);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, en, 1'b0, 0);
      check(name, a, 1'b0, rem, p);
    end
  endtask

  initial begin
    int n;
    //                rst bt en ld dur  act done rem paused
    table_v[0]  = v(1, 0, 1, 0, 0,   0, 0, 0,  0);
    table_v[1]  = v(0, 0, 1, 1, 3,   1, 0, 3,  0);
    table_v[2]  = v(0, 1, 1, 0, 0,   1, 0, 2,  0);
    table_v[3]  = v(0, 0, 1, 0, 0,   1, 0, 2,  0);
    table_v[4]  = v(0, 1, 1, 0, 0,   1, 0, 1,  0);
    table_v[5]  = v(0, 0, 1, 0, 0,   1, 0, 1,  0);
    table_v[6]  = v(0, 1, 1, 0, 0,   0, 1, 0,  0);
    table_v[7]  = v(0, 0, 1, 0, 0,   0, 0, 0,  0);
    table_v[8]  = v(0, 0, 1, 1, 0,   0, 1, 0,  0);
    table_v[9]  = v(0, 0, 1, 0, 0,   0, 0, 0,  0);
    table_v[10] = v(0, 0, 0, 1, 2,   1, 0, 2,  1);
    table_v[11] = v(0, 1, 0, 0, 0,   1, 0, 2,  1);
    table_v[12] = v(0, 0, 1, 0, 0,   1, 0, 2,  0);
    table_v[13] = v(0, 1, 0, 0, 0,   1, 0, 2,  1);
    table_v[14] = v(0, 0, 0, 0, 0,   1, 0, 2,  1);
    table_v[15] = v(0, 1, 1, 0, 0,   1, 0, 2,  0);
    table_v[16] = v(0, 0, 1, 0, 0,   1, 0, 2,  0);
    table_v[17] = v(0, 1, 1, 0, 0,   1, 0, 1,  0);
    table_v[18] = v(0, 0, 1, 0, 0,   1, 0, 1,  0);
    table_v[19] = v(0, 1, 1, 0, 0,   0, 1, 0,  0);
    table_v[20] = v(0, 0, 1, 1, 5,   1, 0, 5,  0);
    table_v[21] = v(0, 1, 1, 0, 0,   1, 0, 4,  0);
    table_v[22] = v(0, 0, 1, 0, 0,   1, 0, 4,  0);
    table_v[23] = v(0, 1, 1, 1, 2,   1, 0, 2,  0);
    table_v[24] = v(0, 0, 1, 0, 0,   1, 0, 2,  0);
    table_v[25] = v(0, 1, 1, 0, 0,   1, 0, 1,  0);
    table_v[26] = v(0, 0, 1, 0, 0,   1, 0, 1,  0);
    table_v[27] = v(1, 1, 1, 0, 0,   0, 0, 0,  0);
    table_v[28] = v(0, 0, 1, 0, 0,   0, 0, 0,  0);
    table_v[29] = v(1, 0, 1, 1, 7,   0, 0, 0,  0);
    table_v[30] = v(0, 0, 1, 1, 7,   1, 0, 7,  0);
    table_v[31] = v(0, 0, 0, 1, 63,  1, 0, 63, 1);
    table_v[32] = v(1, 0, 0, 0, 0,   0, 0, 0,  0);

    for (int i = 0; i < NVEC; i++) begin
      step(table_v[i].rst, table_v[i].bt, table_v[i].en, table_v[i].ld, int'(table_v[i].dur));
      check($sformatf("table[%0d]", i), table_v[i].exp_active, table_v[i].exp_done,
            int'(table_v[i].exp_rem), table_v[i].exp_paused);
    end

    // Duration 3, a beat every 8 cycles.
    step(1, 0, 1, 0, 0);
    check("d3_reset", 0, 0, 0, 0);
    step(0, 0, 1, 1, 3);
    check("d3_load", 1, 0, 3, 0);
    for (int k = 0; k < 3; k++) begin
      idle_hold("d3_gap", 7, 1'b1, 1'b1, 3 - k, 1'b0);
      step(0, 1, 1, 0, 0);
      check($sformatf("d3_beat%0d", k + 1), k != 2, k == 2, 2 - k, 0);
    end
    step(0, 0, 1, 0, 0);
    check("d3_after_done", 0, 0, 0, 0);

    // Duration 4 with a 20-cycle pause containing two beats.
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 4);
    check("d4_load", 1, 0, 4, 0);
    step(0, 1, 1, 0, 0);
    idle_hold("d4_gap1", 3, 1'b1, 1'b1, 3, 1'b0);
    step(0, 1, 1, 0, 0);
    check("d4_two_beats", 1, 0, 2, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, (i == 5 || i == 13), 0, 0, 0);
      check("d4_paused", 1, 0, 2, 1);
    end
    step(0, 0, 1, 0, 0);
    check("d4_resume", 1, 0, 2, 0);
    step(0, 1, 1, 0, 0);
    check("d4_beat3", 1, 0, 1, 0);
    idle_hold("d4_gap2", 3, 1'b1, 1'b1, 1, 1'b0);
    step(0, 1, 1, 0, 0);
    check("d4_done", 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("d4_idle", 0, 0, 0, 0);

    // Zero duration: immediate done, never active.
    step(0, 0, 1, 1, 0);
    check("d0_done", 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("d0_idle", 0, 0, 0, 0);

    // Abort at remaining=5 with a coincident beat.
    step(0, 0, 1, 1, 5);
    check("abort_load5", 1, 0, 5, 0);
    step(0, 1, 1, 1, 2);
    check("abort_reload2", 1, 0, 2, 0);
    idle_hold("abort_no_done", 2, 1'b1, 1'b1, 2, 1'b0);

    // Reset on the final beat abandons the note.
    step(0, 0, 1, 1, 1);
    check("rst_load1", 1, 0, 1, 0);
    step(1, 1, 1, 0, 0);
    check("rst_on_beat", 0, 0, 0, 0);
    idle_hold("rst_no_done", 3, 1'b1, 1'b0, 0, 1'b0);

    // Full-range note: exactly 63 beats.
    step(0, 0, 1, 1, 63);
    check("d63_load", 1, 0, 63, 0);
    n = 0;
    while (!done_with_note && n < 100) begin
      step(0, 1, 1, 0, 0);
      n++;
      check($sformatf("d63_beat%0d", n), n < 63, n == 63, (n <= 63) ? 63 - n : 0, 0);
      if (!done_with_note)
        step(0, 0, 1, 0, 0);
    end
    check_int("d63_beat_count", n, 63);
    step(0, 0, 1, 0, 0);
    check("d63_idle", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
